// File: rtl/slib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slib_pkg
// Brief    : Shared constants and helpers for the slib FIFO family.
// Revision : 1.0 - initial release
// ============================================================================
package slib_pkg;

    localparam int FIFO_STD   = 0;
    localparam int FIFO_FWFT  = 1;

    localparam int SIZE_E_MIN = 1;
    localparam int SIZE_E_MAX = 12;

    function automatic int fifo_depth(input int size_e);
        return 1 << size_e;
    endfunction

    function automatic bit fifo_size_legal(input int size_e);
        return (size_e >= SIZE_E_MIN) && (size_e <= SIZE_E_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slib_fifo_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : slib_fifo_gen_if
// Brief    : Push/pop, level and status bundle of the generic FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface slib_fifo_gen_if #(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6
);
    logic              CLEAR;
    logic              WRITE;
    logic              READ;
    logic [WIDTH-1:0]  D;
    logic [SIZE_E:0]   AFULL_LVL;
    logic [SIZE_E:0]   AEMPTY_LVL;
    logic [WIDTH-1:0]  Q;
    logic              EMPTY;
    logic              FULL;
    logic              AFULL;
    logic              AEMPTY;
    logic [SIZE_E:0]   USAGE;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output CLEAR, WRITE, READ, D, AFULL_LVL, AEMPTY_LVL,
        input  Q, EMPTY, FULL, AFULL, AEMPTY, USAGE, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR, WRITE, READ, D, AFULL_LVL, AEMPTY_LVL,
        output Q, EMPTY, FULL, AFULL, AEMPTY, USAGE, OVERFLOW, UNDERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/slib_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : slib_fifo_ram
// Brief    : Simple dual-port synchronous RAM with registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module slib_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]  i_wr_data,
    input  wire logic              i_rd_en,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]  o_rd_data
);
    localparam int c_WORDS = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [0:c_WORDS-1];

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/slib_fifo_gen.sv
`default_nettype none
// ============================================================================
// Module   : slib_fifo_gen
// Brief    : Generic single-clock FIFO, standard or first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module slib_fifo_gen
    import slib_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6,
    parameter int FWFT   = FIFO_STD
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    slib_fifo_gen_if.slave  bus
);
    localparam logic [SIZE_E:0] c_DEPTH_CNT = (SIZE_E+1)'(fifo_depth(SIZE_E));
    localparam logic [SIZE_E:0] c_ONE       = {{SIZE_E{1'b0}}, 1'b1};

    generate
        if (!fifo_size_legal(SIZE_E)) begin : g_bad_size
            $error("slib_fifo_gen: SIZE_E must lie in 1..12");
        end
    endgenerate

    logic [SIZE_E:0] r_wr_ptr;
    logic [SIZE_E:0] r_rd_ptr;
    logic [SIZE_E:0] r_usage;
    logic            w_empty;
    logic            w_full;
    logic            w_rd_ok;
    logic            w_wr_ok;
    logic            w_load;
    logic            w_ram_we;

    assign w_full   = (r_usage == c_DEPTH_CNT);
    assign w_rd_ok  = bus.READ && !w_empty;
    assign w_wr_ok  = bus.WRITE && (!w_full || w_rd_ok);
    assign w_ram_we = w_wr_ok && !bus.CLEAR;

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            logic r_qvalid;

            // r_rd_ptr tracks the next word still in RAM; the head lives in Q.
            assign w_empty = !r_qvalid;
            assign w_load  = !bus.CLEAR && (w_rd_ok || !r_qvalid) && (r_wr_ptr != r_rd_ptr);

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_qvalid <= 1'b0;
                end else if (bus.CLEAR) begin
                    r_qvalid <= 1'b0;
                end else if (w_rd_ok || !r_qvalid) begin
                    r_qvalid <= (r_wr_ptr != r_rd_ptr);
                end
            end
        end else begin : g_std
            assign w_empty = (r_usage == '0);
            assign w_load  = !bus.CLEAR && w_rd_ok;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else if (bus.CLEAR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_usage <= r_usage + c_ONE;
            end else if (!w_wr_ok && w_rd_ok) begin
                r_usage <= r_usage - c_ONE;
            end
        end
    end

    slib_fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (SIZE_E)
    ) u_ram (
        .CLK       (CLK),
        .RST       (RST),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_wr_ptr[SIZE_E-1:0]),
        .i_wr_data (bus.D),
        .i_rd_en   (w_load),
        .i_rd_addr (r_rd_ptr[SIZE_E-1:0]),
        .o_rd_data (bus.Q)
    );

    assign bus.EMPTY     = w_empty;
    assign bus.FULL      = w_full;
    assign bus.USAGE     = r_usage;
    assign bus.AFULL     = (r_usage >= bus.AFULL_LVL);
    assign bus.AEMPTY    = (r_usage <= bus.AEMPTY_LVL);
    assign bus.OVERFLOW  = !RST && !bus.CLEAR && bus.WRITE && !w_wr_ok;
    assign bus.UNDERFLOW = !RST && !bus.CLEAR && bus.READ && w_empty;
endmodule
`default_nettype wire
